// File: rtl/pcie_ep_sb_pkg.sv
// Shared state encoding, default timing values and output decode helpers
// for the endpoint-side PCIe sideband controller.
package pcie_ep_sb_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_RST_DELAY  = 3'd2,
    ST_ACTIVE     = 3'd3,
    ST_LINK       = 3'd4,
    ST_L2_IDLE    = 3'd5,
    ST_WAKE       = 3'd6
  } ep_state_e;

  localparam int DEF_PERST_FILT   = 16;
  localparam int DEF_RST_HOLD_CYC = 1250;      // 10 us at 125 MHz
  localparam int DEF_WAKE_TMO_CYC = 12500000;  // 100 ms at 125 MHz

  localparam logic [7:0] PERST_CNT_MAX = 8'd255;

  function automatic logic core_rstn_of(input ep_state_e s);
    return (s == ST_ACTIVE) || (s == ST_LINK) || (s == ST_L2_IDLE) || (s == ST_WAKE);
  endfunction

  function automatic logic wake_b_of(input ep_state_e s);
    return (s != ST_WAKE);
  endfunction

  // CLKREQ# is released only while parked in L2; a wake re-requests refclk.
  function automatic logic clkreq_b_of(input ep_state_e s);
    return (s == ST_L2_IDLE);
  endfunction

endpackage

// File: rtl/pcie_sb_sync_filter.sv
// 2-FF synchroniser followed by an optional stability filter; FILT_LEN=0
// gives a plain synchroniser.
module pcie_sb_sync_filter #(
  parameter int FILT_LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic sync1_reg;
  logic sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign dout = sync2_reg;
    end else begin : g_filt
      localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
      localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

      logic [CW-1:0] cnt_reg;
      logic          filt_reg;

      // The filtered value only moves after FILT_LEN consecutive disagreeing samples.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg  <= '0;
          filt_reg <= 1'b0;
        end else if (sync2_reg != filt_reg) begin
          if (cnt_reg == CNT_LAST) begin
            filt_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign dout = filt_reg;
    end
  endgenerate

endmodule

// File: rtl/pcie_ep_sideband_ctrl.sv
// Endpoint PCIe sideband manager: filters PERST#, sequences core reset
// against refclk lock and drives WAKE#/CLKREQ# from link/power state.
module pcie_ep_sideband_ctrl
  import pcie_ep_sb_pkg::*;
#(
  parameter int PERST_FILT   = DEF_PERST_FILT,
  parameter int RST_HOLD_CYC = DEF_RST_HOLD_CYC,
  parameter int WAKE_TMO_CYC = DEF_WAKE_TMO_CYC
) (
  input  logic       bd_fclk0_125m,
  input  logic       bd_sys_rstn,
  input  logic       pcie_perst_b,
  input  logic       pcie_dbg_mmcm_lock,
  input  logic       ep_link_up,
  input  logic       ep_pm_l2,
  input  logic       ep_wake_req,
  output logic       ep_core_rstn,
  output logic       pcie_wake_b,
  output logic       pcie_clkreq_b,
  output logic [2:0] ep_state,
  output logic [7:0] perst_cnt,
  output logic       wake_timeout
);

  localparam int DLY_W  = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
  localparam int WAKE_W = (WAKE_TMO_CYC > 1) ? $clog2(WAKE_TMO_CYC) : 1;
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(RST_HOLD_CYC - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_TMO_CYC - 1);

  logic perst_f;
  logic lock_s;
  logic link_s;

  pcie_sb_sync_filter #(.FILT_LEN(PERST_FILT)) u_perst_filt (
    .clk   (bd_fclk0_125m),
    .rst_n (bd_sys_rstn),
    .din   (pcie_perst_b),
    .dout  (perst_f)
  );

  pcie_sb_sync_filter #(.FILT_LEN(0)) u_lock_sync (
    .clk   (bd_fclk0_125m),
    .rst_n (bd_sys_rstn),
    .din   (pcie_dbg_mmcm_lock),
    .dout  (lock_s)
  );

  pcie_sb_sync_filter #(.FILT_LEN(0)) u_link_sync (
    .clk   (bd_fclk0_125m),
    .rst_n (bd_sys_rstn),
    .din   (ep_link_up),
    .dout  (link_s)
  );

  ep_state_e         state_reg, state_next;
  logic [DLY_W-1:0]  dly_cnt_reg, dly_cnt_next;
  logic [WAKE_W-1:0] wake_cnt_reg, wake_cnt_next;
  logic              wake_tmo_set;
  logic              wake_tmo_reg;
  logic              perst_f_d_reg;
  logic [7:0]        perst_cnt_reg;
  logic              core_rstn_reg;
  logic              wake_b_reg;
  logic              clkreq_b_reg;

  // Counters default to zero so leaving a timed state always clears them.
  always_comb begin
    state_next    = state_reg;
    dly_cnt_next  = '0;
    wake_cnt_next = '0;
    wake_tmo_set  = 1'b0;
    if (!perst_f) begin
      state_next = ST_RESET_HOLD;
    end else begin
      case (state_reg)
        ST_RESET_HOLD: state_next = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_s) state_next = ST_RST_DELAY;
        end
        ST_RST_DELAY: begin
          if (!lock_s) begin
            state_next = ST_WAIT_LOCK;
          end else if (dly_cnt_reg == DLY_LAST) begin
            state_next = ST_ACTIVE;
          end else begin
            dly_cnt_next = dly_cnt_reg + DLY_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (!lock_s)     state_next = ST_WAIT_LOCK;
          else if (link_s) state_next = ST_LINK;
        end
        ST_LINK: begin
          if (!lock_s)       state_next = ST_WAIT_LOCK;
          else if (ep_pm_l2) state_next = ST_L2_IDLE;
          else if (!link_s)  state_next = ST_ACTIVE;
        end
        ST_L2_IDLE: begin
          if (ep_wake_req) state_next = ST_WAKE;
        end
        ST_WAKE: begin
          // A PERST# response is handled by the override above; this is the give-up path.
          if (wake_cnt_reg == WAKE_LAST) begin
            state_next   = ST_L2_IDLE;
            wake_tmo_set = 1'b1;
          end else begin
            wake_cnt_next = wake_cnt_reg + WAKE_W'(1);
          end
        end
        default: state_next = ST_RESET_HOLD;
      endcase
    end
  end

  always_ff @(posedge bd_fclk0_125m or negedge bd_sys_rstn) begin
    if (!bd_sys_rstn) begin
      state_reg     <= ST_RESET_HOLD;
      dly_cnt_reg   <= '0;
      wake_cnt_reg  <= '0;
      wake_tmo_reg  <= 1'b0;
      perst_f_d_reg <= 1'b0;
      perst_cnt_reg <= '0;
      core_rstn_reg <= 1'b0;
      wake_b_reg    <= 1'b1;
      clkreq_b_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dly_cnt_reg   <= dly_cnt_next;
      wake_cnt_reg  <= wake_cnt_next;
      perst_f_d_reg <= perst_f;
      if (wake_tmo_set) wake_tmo_reg <= 1'b1;
      if (perst_f_d_reg && !perst_f && (perst_cnt_reg != PERST_CNT_MAX))
        perst_cnt_reg <= perst_cnt_reg + 8'd1;
      core_rstn_reg <= core_rstn_of(state_next);
      wake_b_reg    <= wake_b_of(state_next);
      clkreq_b_reg  <= clkreq_b_of(state_next);
    end
  end

  assign ep_state      = state_reg;
  assign ep_core_rstn  = core_rstn_reg;
  assign pcie_wake_b   = wake_b_reg;
  assign pcie_clkreq_b = clkreq_b_reg;
  assign perst_cnt     = perst_cnt_reg;
  assign wake_timeout  = wake_tmo_reg;

endmodule

// File: tb/tb_pcie_ep_sideband_ctrl.sv
// Directed bench for pcie_ep_sideband_ctrl with short filter/delay/timeout
// settings; table-driven vectors plus hand sequences for latency and saturation.
module tb_pcie_ep_sideband_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       perst_b, lock, link, pm_l2, wake_req;
  logic       core_rstn, wake_b, clkreq_b, wake_tmo;
  logic [2:0] st;
  logic [7:0] pcnt;

  int checks = 0;
  int failures = 0;

  always #4 clk = ~clk;

  pcie_ep_sideband_ctrl #(
    .PERST_FILT   (4),
    .RST_HOLD_CYC (10),
    .WAKE_TMO_CYC (20)
  ) dut (
    .bd_fclk0_125m      (clk),
    .bd_sys_rstn        (rst_n),
    .pcie_perst_b       (perst_b),
    .pcie_dbg_mmcm_lock (lock),
    .ep_link_up         (link),
    .ep_pm_l2           (pm_l2),
    .ep_wake_req        (wake_req),
    .ep_core_rstn       (core_rstn),
    .pcie_wake_b        (wake_b),
    .pcie_clkreq_b      (clkreq_b),
    .ep_state           (st),
    .perst_cnt          (pcnt),
    .wake_timeout       (wake_tmo)
  );

  typedef struct {
    logic       perst_b, lock, link, pm_l2, wake_req;
    int         cycles;
    logic [2:0] st;
    logic       rstn, wake_b, clkreq_b, tmo;
    logic [7:0] pcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic p, input logic l, input logic k, input logic m,
                              input logic w, input int c, input int s, input logic r,
                              input logic wb, input logic cr, input logic t, input int pc);
    vec_t v;
    v.perst_b = p; v.lock = l; v.link = k; v.pm_l2 = m; v.wake_req = w;
    v.cycles = c; v.st = 3'(s); v.rstn = r; v.wake_b = wb; v.clkreq_b = cr;
    v.tmo = t; v.pcnt = 8'(pc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " state"}, 32'(st), 32'(v.st));
    chk({tag, " core_rstn"}, 32'(core_rstn), 32'(v.rstn));
    chk({tag, " wake_b"}, 32'(wake_b), 32'(v.wake_b));
    chk({tag, " clkreq_b"}, 32'(clkreq_b), 32'(v.clkreq_b));
    chk({tag, " wake_timeout"}, 32'(wake_tmo), 32'(v.tmo));
    chk({tag, " perst_cnt"}, 32'(pcnt), 32'(v.pcnt));
  endtask

  initial begin
    int exp_st;
    int exp_cnt;
    vec_t rv;

    rst_n = 1'b0; perst_b = 1'b0; lock = 1'b1; link = 1'b0; pm_l2 = 1'b0; wake_req = 1'b0;
    repeat (3) tick();
    rv = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk_all("reset", rv);
    $display("reset: state=%0d core_rstn=%0b wake_b=%0b clkreq_b=%0b", st, core_rstn, wake_b, clkreq_b);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("held_by_perst state", 32'(st), 32'd0);

    // PERST# release with lock already high: core reset lifts 18 cycles later.
    perst_b = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      tick();
      exp_st = (n < 7) ? 0 : (n == 7) ? 1 : (n < 18) ? 2 : 3;
      chk($sformatf("bringup c%0d state", n), 32'(st), 32'(exp_st));
      chk($sformatf("bringup c%0d core_rstn", n), 32'(core_rstn), (n == 18) ? 32'd1 : 32'd0);
    end
    $display("bringup: state=%0d core_rstn=%0b after 18 cycles", st, core_rstn);

    //                perst lock link pm wake cyc  st rstn wb cr tmo cnt
    vecs.push_back(mk(0, 1, 0, 0, 0,  3, 3, 1, 1, 0, 0, 0));  // 3-cycle glitch
    vecs.push_back(mk(1, 1, 0, 0, 0,  6, 3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  8, 0, 0, 1, 0, 0, 1));  // real PERST# assert
    vecs.push_back(mk(1, 1, 0, 0, 0, 18, 3, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 4, 1, 1, 0, 0, 1));  // link up
    vecs.push_back(mk(1, 0, 1, 0, 0,  1, 4, 1, 1, 0, 0, 1));  // 1-cycle lock loss
    vecs.push_back(mk(1, 1, 1, 0, 0,  2, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 2, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0,  9, 2, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 3, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 4, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0,  2, 4, 1, 1, 0, 0, 1));  // link down, no L2
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 3, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 4, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0,  1, 5, 1, 1, 1, 0, 1));  // L2 entry
    vecs.push_back(mk(1, 1, 1, 1, 1,  1, 6, 1, 0, 0, 0, 1));  // wake
    vecs.push_back(mk(0, 1, 1, 1, 0,  6, 6, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0,  1, 0, 0, 1, 0, 0, 2));  // host answers with PERST#
    vecs.push_back(mk(1, 1, 0, 0, 0, 18, 3, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 1,  1, 3, 1, 1, 0, 0, 2));  // wake ignored in ACTIVE
    vecs.push_back(mk(1, 1, 0, 0, 0,  2, 3, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 4, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0,  2, 4, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0, 1, 0,  1, 5, 1, 1, 1, 0, 2));  // pm_l2 beats link-down
    vecs.push_back(mk(1, 1, 0, 0, 0,  3, 5, 1, 1, 1, 0, 2));  // no queued wake
    vecs.push_back(mk(1, 1, 0, 0, 1,  1, 6, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 19, 6, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 5, 1, 1, 1, 1, 2));  // wake timeout

    for (int i = 0; i < vecs.size(); i++) begin
      perst_b = vecs[i].perst_b; lock = vecs[i].lock; link = vecs[i].link;
      pm_l2 = vecs[i].pm_l2; wake_req = vecs[i].wake_req;
      tick();
      wake_req = 1'b0;
      for (int c = 1; c < vecs[i].cycles; c++) tick();
      chk_all($sformatf("vec%0d", i), vecs[i]);
      $display("vec%0d: state=%0d core_rstn=%0b wake_b=%0b clkreq_b=%0b tmo=%0b perst_cnt=%0d",
               i, st, core_rstn, wake_b, clkreq_b, wake_tmo, pcnt);
    end

    // Saturation of the PERST# assertion counter.
    exp_cnt = 2;
    for (int p = 0; p < 300; p++) begin
      perst_b = 1'b0;
      repeat (8) tick();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk($sformatf("pulse%0d perst_cnt", p), 32'(pcnt), 32'(exp_cnt));
      perst_b = 1'b1;
      repeat (8) tick();
    end
    $display("pulses: 300 applied perst_cnt=%0d", pcnt);
    chk("sat state", 32'(st), 32'd2);
    chk("sat wake_timeout", 32'(wake_tmo), 32'd1);

    // Asynchronous reset in the middle of RST_DELAY.
    #2;
    rst_n = 1'b0;
    #1;
    rv = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk_all("midreset", rv);
    $display("midreset: state=%0d core_rstn=%0b perst_cnt=%0d tmo=%0b", st, core_rstn, pcnt, wake_tmo);
    #5;
    rst_n = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
